write_priority_arbiter: RTL and testbench

- Consumes the per-port priority and destination fields produced by the write-path priority decoder.
- Picks one requesting input port per packet and drives the 4-bit `select` that the decoder and write datapath use to track `eop`.
- Holds the grant until end-of-packet or a watchdog timeout.
- Breaks ties between equal-priority requesters round-robin.

---
 rtl/write_priority_arbiter.sv | 144 ++++++++++++++
 tb/tb_write_priority_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/write_priority_arbiter.sv
// Write-path arbiter: picks one requesting port per packet by priority,
// round-robin among equal priorities, and holds it until eop or watchdog.
// Ports: clk, rst (sync, active-low), ready/eop per port, packed
// priority_in/des_port_in in; select, grant, grant_valid,
// grant_priority, grant_des_port, timeout out.
module write_priority_arbiter #(
  parameter int num_of_ports   = 16,
  parameter int priority_width = 3,
  parameter int des_port_width = 4,
  parameter int timeout_cycles = 1024,
  parameter int cnt_width      = 11
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [num_of_ports-1:0]                  ready,
  input  logic [num_of_ports-1:0]                  eop,
  input  logic [num_of_ports*priority_width-1:0]   priority_in,
  input  logic [num_of_ports*des_port_width-1:0]   des_port_in,
  output logic [3:0]                               select,
  output logic [num_of_ports-1:0]                  grant,
  output logic                                     grant_valid,
  output logic [priority_width-1:0]                grant_priority,
  output logic [des_port_width-1:0]                grant_des_port,
  output logic                                     timeout
);

  localparam int IW = $clog2(num_of_ports);
  localparam logic [cnt_width-1:0] CNT_LAST =
    cnt_width'(timeout_cycles - 1);

  typedef enum logic [1:0] {
    IDLE, ARB, GRANT, RELEASE
  } state_t;

  state_t state, state_nxt;

  logic [3:0]                sel_q;
  logic [3:0]                rr_ptr;
  logic [3:0]                rr_nxt;
  logic [priority_width-1:0] pri_q;
  logic [des_port_width-1:0] des_q;
  logic [cnt_width-1:0]      cnt;
  logic                      tmo_q;

  logic                      win_found;
  logic [3:0]                win_idx;
  logic [priority_width-1:0] win_pri;
  logic [des_port_width-1:0] win_des;
  logic                      eop_sel;
  logic                      cnt_hit;

  // Scan upward from rr_ptr; strict '>' keeps the first tied port.
  always_comb begin : arb_c
    logic [IW-1:0] idx;
    logic [priority_width-1:0] p;
    win_found = 1'b0;
    win_idx   = '0;
    win_pri   = '0;
    win_des   = '0;
    idx       = '0;
    p         = '0;
    for (int k = 0; k < num_of_ports; k++) begin
      idx = IW'((int'(rr_ptr) + k) % num_of_ports);
      p = priority_in[int'(idx)*priority_width +: priority_width];
      if (ready[idx] && (!win_found || p > win_pri)) begin
        win_found = 1'b1;
        win_idx   = 4'(idx);
        win_pri   = p;
        win_des   =
          des_port_in[int'(idx)*des_port_width +: des_port_width];
      end
    end
  end

  assign eop_sel = eop[IW'(sel_q)];
  assign cnt_hit = (cnt == CNT_LAST);
  assign rr_nxt  = (sel_q == 4'(num_of_ports - 1)) ?
                   4'd0 : sel_q + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|ready) state_nxt = ARB;
      ARB:     state_nxt = win_found ? GRANT : IDLE;
      GRANT:   if (eop_sel || cnt_hit) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_q  <= '0;
      rr_ptr <= '0;
      pri_q  <= '0;
      des_q  <= '0;
      cnt    <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state)
        ARB: begin
          if (win_found) begin
            sel_q <= win_idx;
            pri_q <= win_pri;
            des_q <= win_des;
            cnt   <= '0;
          end
        end
        GRANT: begin
          // eop takes precedence over the watchdog on the same cycle
          if (eop_sel) begin
            rr_ptr <= rr_nxt;
          end else if (cnt_hit) begin
            rr_ptr <= rr_nxt;
            tmo_q  <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    grant_valid       = (state == GRANT);
    grant             = '0;
    grant[IW'(sel_q)] = grant_valid;
    select            = sel_q;
    grant_priority    = pri_q;
    grant_des_port    = des_q;
    timeout           = tmo_q;
  end

endmodule

// File: tb/tb_write_priority_arbiter.sv
// Directed bench for write_priority_arbiter (timeout_cycles=8).
// Checks reset, priority pick, round-robin, eop isolation, watchdog.
module tb_write_priority_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] ready;
  logic [15:0] eop;
  logic [47:0] priority_in;
  logic [63:0] des_port_in;
  logic [3:0]  select;
  logic [15:0] grant;
  logic        grant_valid;
  logic [2:0]  grant_priority;
  logic [3:0]  grant_des_port;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  write_priority_arbiter #(
    .num_of_ports(16),
    .priority_width(3),
    .des_port_width(4),
    .timeout_cycles(8),
    .cnt_width(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ready(ready),
    .eop(eop),
    .priority_in(priority_in),
    .des_port_in(des_port_in),
    .select(select),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_priority(grant_priority),
    .grant_des_port(grant_des_port),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [2:0] pri,
                          input logic [3:0] des);
    priority_in[p*3 +: 3] = pri;
    des_port_in[p*4 +: 4] = des;
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!grant_valid && n < 10) begin
      tick();
      n++;
    end
    if (!grant_valid) chk("grant_wait", 0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gv"}, 32'(grant_valid), 0);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_sel"}, 32'(select), 0);
    chk({tag, "_pri"}, 32'(grant_priority), 0);
    chk({tag, "_des"}, 32'(grant_des_port), 0);
    chk({tag, "_tmo"}, 32'(timeout), 0);
  endtask

  int exp_rr[4] = '{1, 5, 9, 1};
  int n;

  initial begin
    rst = 1'b0;
    ready = 16'hFFFF;
    eop = '0;
    priority_in = '0;
    des_port_in = '0;

    // reset with all ports requesting
    repeat (3) tick();
    chk_zero("rst");
    rst = 1'b1;
    tick();
    chk("lat1_gv", 32'(grant_valid), 0);
    tick();
    chk("lat2_gv", 32'(grant_valid), 1);
    chk("lat2_sel", 32'(select), 0);
    ready = '0;
    eop = 16'h0001;
    tick();
    chk("lat_rel_gv", 32'(grant_valid), 0);
    eop = '0;
    tick();

    // priority pick
    set_port(2, 3'd3, 4'hA);
    set_port(4, 3'd6, 4'h5);
    ready = 16'h0014;
    tick();
    tick();
    chk("pick_gv", 32'(grant_valid), 1);
    chk("pick_sel", 32'(select), 4);
    chk("pick_grant", 32'(grant), 32'h0010);
    chk("pick_pri", 32'(grant_priority), 6);
    chk("pick_des", 32'(grant_des_port), 5);

    // eop on another port and dropped ready are ignored
    eop = 16'h0008;
    ready = 16'h0004;
    tick();
    eop = '0;
    chk("iso_gv", 32'(grant_valid), 1);
    chk("iso_sel", 32'(select), 4);
    tick();
    chk("iso_gv2", 32'(grant_valid), 1);
    ready = '0;
    eop = 16'h0010;
    tick();
    eop = '0;
    chk("iso_rel_gv", 32'(grant_valid), 0);
    chk("iso_rel_grant", 32'(grant), 0);
    chk("iso_rel_sel", 32'(select), 4);
    chk("iso_rel_pri", 32'(grant_priority), 6);
    tick();
    chk("iso_idle_gv", 32'(grant_valid), 0);

    // round-robin among equal priorities from rr_ptr=0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_port(1, 3'd5, 4'h1);
    set_port(5, 3'd5, 4'h2);
    set_port(9, 3'd5, 4'h3);
    ready = 16'h0222;
    for (int i = 0; i < 4; i++) begin
      wait_grant();
      chk($sformatf("rr%0d_sel", i), 32'(select), 32'(exp_rr[i]));
      chk($sformatf("rr%0d_grant", i), 32'(grant),
          32'h1 << exp_rr[i]);
      eop = 16'h1 << exp_rr[i];
      tick();
      eop = '0;
      chk($sformatf("rr%0d_rel", i), 32'(grant_valid), 0);
    end
    ready = '0;
    tick();

    // watchdog: port 7 never ends its packet
    set_port(7, 3'd2, 4'h7);
    ready = 16'h0080;
    wait_grant();
    ready = '0;
    chk("tmo_sel", 32'(select), 7);
    n = 1;
    while (grant_valid && n < 20) begin
      tick();
      if (grant_valid) n++;
    end
    chk("tmo_len", 32'(n), 8);
    chk("tmo_pulse", 32'(timeout), 1);
    tick();
    chk("tmo_pulse_end", 32'(timeout), 0);

    // rr_ptr is now 8, so port 9 beats port 7; eop on the last cycle
    set_port(9, 3'd2, 4'h3);
    ready = 16'h0280;
    wait_grant();
    ready = '0;
    chk("rr8_sel", 32'(select), 9);
    repeat (7) tick();
    chk("eop8_gv", 32'(grant_valid), 1);
    eop = 16'h0200;
    tick();
    eop = '0;
    chk("eop8_gv_low", 32'(grant_valid), 0);
    chk("eop8_tmo", 32'(timeout), 0);
    tick();

    // reset in the middle of a grant
    set_port(3, 3'd4, 4'h6);
    set_port(11, 3'd4, 4'hC);
    ready = 16'h0808;
    wait_grant();
    chk("mid_sel", 32'(select), 11);
    chk("mid_des", 32'(grant_des_port), 32'hC);
    tick();
    rst = 1'b0;
    tick();
    chk_zero("mid_rst");
    rst = 1'b1;
    tick();
    chk("mid_lat1", 32'(grant_valid), 0);
    tick();
    chk("mid_lat2", 32'(grant_valid), 1);
    chk("mid_rr0_sel", 32'(select), 3);
    chk("mid_rr0_des", 32'(grant_des_port), 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
